// File: rtl/mmu_pkg.sv
// Shared MMU definitions: TLB sweep FSM states, stats counter width and
// tree pseudo-LRU helpers sized for up to 8 ways (narrower trees use the low bits).
package mmu_pkg;

    localparam int STATS_CNT_W   = 32;
    localparam int PLRU_MAX_BITS = 7;
    localparam int WAY_MAX_W     = 3;

    localparam logic [PLRU_MAX_BITS-1:0] PLRU_ONE = 7'd1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } tlb_state_e;

    function automatic int unsigned plru_levels(input int unsigned ways);
        int unsigned levels;
        case (ways)
            8:       levels = 3;
            4:       levels = 2;
            2:       levels = 1;
            default: levels = 0;
        endcase
        return levels;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    // A node bit of 1 means the upper half is the less-recently-used one.
    function automatic logic [PLRU_MAX_BITS-1:0] plru_update(
        input int unsigned                ways,
        input logic [PLRU_MAX_BITS-1:0]   bits,
        input logic [WAY_MAX_W-1:0]       way
    );
        logic [PLRU_MAX_BITS-1:0] nb;
        logic [WAY_MAX_W-1:0]     sh;
        int unsigned              node;
        int unsigned              levels;
        nb     = bits;
        node   = 0;
        levels = plru_levels(ways);
        for (int unsigned lvl = 0; lvl < WAY_MAX_W; lvl++) begin
            if (lvl < levels) begin
                sh   = way >> (levels - 1 - lvl);
                nb   = (nb & ~(PLRU_ONE << node))
                     | ({{(PLRU_MAX_BITS-1){1'b0}}, ~sh[0]} << node);
                node = 2 * node + 1 + (sh[0] ? 1 : 0);
            end
        end
        return nb;
    endfunction

    function automatic logic [WAY_MAX_W-1:0] plru_victim(
        input int unsigned                ways,
        input logic [PLRU_MAX_BITS-1:0]   bits
    );
        logic [WAY_MAX_W-1:0]     v;
        logic [PLRU_MAX_BITS-1:0] cur;
        int unsigned              node;
        int unsigned              levels;
        v      = '0;
        node   = 0;
        levels = plru_levels(ways);
        for (int unsigned lvl = 0; lvl < WAY_MAX_W; lvl++) begin
            if (lvl < levels) begin
                cur  = bits >> node;
                v    = {v[WAY_MAX_W-2:0], cur[0]};
                node = 2 * node + 1 + (cur[0] ? 1 : 0);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/tlb_plru_tree.sv
// Combinational tree pseudo-LRU: next tree state after touching a way,
// and the victim way selected by the current tree state.
module tlb_plru_tree
    import mmu_pkg::*;
#(
    parameter int  WAYS      = 4,
    localparam int PLRU_W    = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int WAY_WIDTH = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PLRU_W-1:0]    cur_bits,
    input  logic [WAY_WIDTH-1:0] access_way,
    output logic [PLRU_W-1:0]    new_bits,
    output logic [WAY_WIDTH-1:0] victim
);

    assign new_bits = PLRU_W'(plru_update(WAYS, PLRU_MAX_BITS'(cur_bits),
                                          WAY_MAX_W'(access_way)));
    assign victim   = WAY_WIDTH'(plru_victim(WAYS, PLRU_MAX_BITS'(cur_bits)));

endmodule

// File: rtl/tlb_tag_array.sv
// N-way set-associative TLB tag/payload store with registered lookup, duplicate-free
// fill, PLRU replacement and init/flush sweep. Define TLB_TAG_ARRAY_STATS_EN for hit/miss counters.
module tlb_tag_array
    import mmu_pkg::*;
#(
    parameter int  IDX_WIDTH     = 6,
    parameter int  TAG_WIDTH     = 20,
    parameter int  PAYLOAD_WIDTH = 32,
    parameter int  WAYS          = 4,
    localparam int WAY_WIDTH     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     lkp_valid_i,
    output logic                     lkp_ready_o,
    input  logic [IDX_WIDTH-1:0]     lkp_idx_i,
    input  logic [TAG_WIDTH-1:0]     lkp_tag_i,
    output logic                     rsp_valid_o,
    output logic                     rsp_hit_o,
    output logic [WAY_WIDTH-1:0]     rsp_way_o,
    output logic [PAYLOAD_WIDTH-1:0] rsp_payload_o,
    input  logic                     fill_valid_i,
    output logic                     fill_ready_o,
    input  logic [IDX_WIDTH-1:0]     fill_idx_i,
    input  logic [TAG_WIDTH-1:0]     fill_tag_i,
    input  logic [PAYLOAD_WIDTH-1:0] fill_payload_i,
    input  logic                     flush_i,
    output logic                     busy_o,
    output logic [STATS_CNT_W-1:0]   hit_cnt_o,
    output logic [STATS_CNT_W-1:0]   miss_cnt_o
);

    localparam int SETS   = 2 ** IDX_WIDTH;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    if (!(WAYS == 1 || WAYS == 2 || WAYS == 4 || WAYS == 8)) begin : g_bad_ways
        $error("tlb_tag_array: WAYS must be 1, 2, 4 or 8");
    end

    tlb_state_e           state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    logic [WAYS-1:0]          valid_q   [SETS];
    logic [TAG_WIDTH-1:0]     tag_q     [SETS][WAYS];
    logic [PAYLOAD_WIDTH-1:0] payload_q [SETS][WAYS];

    logic                     lkp_fire, fill_fire;
    logic                     lkp_hit;
    logic [WAY_WIDTH-1:0]     lkp_way;
    logic [PAYLOAD_WIDTH-1:0] lkp_payload;
    logic                     fill_match, fill_free;
    logic [WAY_WIDTH-1:0]     fill_match_way, fill_free_way, fill_victim, fill_way;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lkp_ready_o  = 1'b0;
        fill_ready_o = 1'b0;
        busy_o       = 1'b1;
        unique case (state_q)
            INIT, FLUSH: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = RUN;
            end
            RUN: begin
                lkp_ready_o  = 1'b1;
                fill_ready_o = 1'b1;
                busy_o       = 1'b0;
                if (flush_i) begin
                    state_d = FLUSH;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
            end
        endcase
    end

    assign lkp_fire  = lkp_valid_i & lkp_ready_o;
    assign fill_fire = fill_valid_i & fill_ready_o;

    // Descending scan so the lowest-numbered matching way is the one that sticks.
    always_comb begin
        lkp_hit     = 1'b0;
        lkp_way     = '0;
        lkp_payload = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lkp_idx_i][w] && (tag_q[lkp_idx_i][w] == lkp_tag_i)) begin
                lkp_hit     = 1'b1;
                lkp_way     = WAY_WIDTH'(w);
                lkp_payload = payload_q[lkp_idx_i][w];
            end
        end
    end

    always_comb begin
        fill_match     = 1'b0;
        fill_match_way = '0;
        fill_free      = 1'b0;
        fill_free_way  = '0;
        fill_way       = fill_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[fill_idx_i][w] && (tag_q[fill_idx_i][w] == fill_tag_i)) begin
                fill_match     = 1'b1;
                fill_match_way = WAY_WIDTH'(w);
            end
            if (!valid_q[fill_idx_i][w]) begin
                fill_free     = 1'b1;
                fill_free_way = WAY_WIDTH'(w);
            end
        end
        if (fill_match)     fill_way = fill_match_way;
        else if (fill_free) fill_way = fill_free_way;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_way_o     <= '0;
            rsp_payload_o <= '0;
        end else begin
            rsp_valid_o   <= lkp_fire;
            rsp_hit_o     <= lkp_fire & lkp_hit;
            rsp_way_o     <= lkp_fire ? lkp_way : '0;
            rsp_payload_o <= lkp_fire ? lkp_payload : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q != RUN) begin
            valid_q[ptr_q] <= '0;
        end else if (fill_fire) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_way == WAY_WIDTH'(w)) valid_q[fill_idx_i][w] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_fire) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_way == WAY_WIDTH'(w)) begin
                    tag_q[fill_idx_i][w]     <= fill_tag_i;
                    payload_q[fill_idx_i][w] <= fill_payload_i;
                end
            end
        end
    end

    if (WAYS > 1) begin : g_plru
        logic [PLRU_W-1:0]    plru_q [SETS];
        logic [PLRU_W-1:0]    lkp_plru_new, fill_plru_new;
        logic [WAY_WIDTH-1:0] unused_lkp_victim;

        tlb_plru_tree #(.WAYS(WAYS)) u_lkp_plru (
            .cur_bits   (plru_q[lkp_idx_i]),
            .access_way (lkp_way),
            .new_bits   (lkp_plru_new),
            .victim     (unused_lkp_victim)
        );

        tlb_plru_tree #(.WAYS(WAYS)) u_fill_plru (
            .cur_bits   (plru_q[fill_idx_i]),
            .access_way (fill_way),
            .new_bits   (fill_plru_new),
            .victim     (fill_victim)
        );

        // Fill update is written last so it overrides a same-set lookup hit.
        always_ff @(posedge clk) begin
            if (state_q != RUN) begin
                plru_q[ptr_q] <= '0;
            end else begin
                if (lkp_fire && lkp_hit) plru_q[lkp_idx_i] <= lkp_plru_new;
                if (fill_fire)           plru_q[fill_idx_i] <= fill_plru_new;
            end
        end
    end else begin : g_no_plru
        assign fill_victim = '0;
    end

`ifdef TLB_TAG_ARRAY_STATS_EN
    logic [STATS_CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == RUN && flush_i)) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rsp_valid_o) begin
            if (rsp_hit_o) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tlb_tag_array.sv
// Directed self-checking bench for tlb_tag_array (WAYS=4, IDX_WIDTH=2).
// Counter expectations follow TLB_TAG_ARRAY_STATS_EN.
module tb_tlb_tag_array;

    localparam int IDX_WIDTH     = 2;
    localparam int TAG_WIDTH     = 20;
    localparam int PAYLOAD_WIDTH = 32;
    localparam int WAYS          = 4;
    localparam int WAY_WIDTH     = 2;

`ifdef TLB_TAG_ARRAY_STATS_EN
    localparam logic [31:0] EXP_HITS   = 32'd11;
    localparam logic [31:0] EXP_MISSES = 32'd3;
`else
    localparam logic [31:0] EXP_HITS   = 32'd0;
    localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     lkp_valid_i = 1'b0;
    logic                     lkp_ready_o;
    logic [IDX_WIDTH-1:0]     lkp_idx_i = '0;
    logic [TAG_WIDTH-1:0]     lkp_tag_i = '0;
    logic                     rsp_valid_o;
    logic                     rsp_hit_o;
    logic [WAY_WIDTH-1:0]     rsp_way_o;
    logic [PAYLOAD_WIDTH-1:0] rsp_payload_o;
    logic                     fill_valid_i = 1'b0;
    logic                     fill_ready_o;
    logic [IDX_WIDTH-1:0]     fill_idx_i = '0;
    logic [TAG_WIDTH-1:0]     fill_tag_i = '0;
    logic [PAYLOAD_WIDTH-1:0] fill_payload_i = '0;
    logic                     flush_i = 1'b0;
    logic                     busy_o;
    logic [31:0]              hit_cnt_o;
    logic [31:0]              miss_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_tag_array #(
        .IDX_WIDTH     (IDX_WIDTH),
        .TAG_WIDTH     (TAG_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .WAYS          (WAYS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lkp_valid_i    (lkp_valid_i),
        .lkp_ready_o    (lkp_ready_o),
        .lkp_idx_i      (lkp_idx_i),
        .lkp_tag_i      (lkp_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_way_o      (rsp_way_o),
        .rsp_payload_o  (rsp_payload_o),
        .fill_valid_i   (fill_valid_i),
        .fill_ready_o   (fill_ready_o),
        .fill_idx_i     (fill_idx_i),
        .fill_tag_i     (fill_tag_i),
        .fill_payload_i (fill_payload_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests, then return them to idle just after the edge.
    task automatic applyStimulus(input logic lv, input logic [IDX_WIDTH-1:0] li,
                                 input logic [TAG_WIDTH-1:0] lt, input logic fv,
                                 input logic [IDX_WIDTH-1:0] fi,
                                 input logic [TAG_WIDTH-1:0] ft,
                                 input logic [PAYLOAD_WIDTH-1:0] fp, input logic fl);
        lkp_valid_i    = lv;
        lkp_idx_i      = li;
        lkp_tag_i      = lt;
        fill_valid_i   = fv;
        fill_idx_i     = fi;
        fill_tag_i     = ft;
        fill_payload_i = fp;
        flush_i        = fl;
        tick();
        lkp_valid_i  = 1'b0;
        fill_valid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic checkResponse(input string name, input logic hit,
                                 input logic [WAY_WIDTH-1:0] way,
                                 input logic [PAYLOAD_WIDTH-1:0] pay);
        checkOutput({name, ".valid"},   32'(rsp_valid_o),   32'd1);
        checkOutput({name, ".hit"},     32'(rsp_hit_o),     32'(hit));
        checkOutput({name, ".way"},     32'(rsp_way_o),     32'(way));
        checkOutput({name, ".payload"}, 32'(rsp_payload_o), 32'(pay));
    endtask

    task automatic lookup(input string name, input logic [IDX_WIDTH-1:0] idx,
                          input logic [TAG_WIDTH-1:0] tag, input logic hit,
                          input logic [WAY_WIDTH-1:0] way,
                          input logic [PAYLOAD_WIDTH-1:0] pay);
        applyStimulus(1'b1, idx, tag, 1'b0, '0, '0, '0, 1'b0);
        checkResponse(name, hit, way, pay);
    endtask

    task automatic fill(input logic [IDX_WIDTH-1:0] idx, input logic [TAG_WIDTH-1:0] tag,
                        input logic [PAYLOAD_WIDTH-1:0] pay);
        applyStimulus(1'b0, '0, '0, 1'b1, idx, tag, pay, 1'b0);
    endtask

    task automatic countWhileBusy(output int n);
        n = 0;
        while (busy_o && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int n;

        tick();
        checkOutput("reset.rsp_valid", 32'(rsp_valid_o),   32'd0);
        checkOutput("reset.rsp_hit",   32'(rsp_hit_o),     32'd0);
        checkOutput("reset.rsp_pay",   rsp_payload_o,      32'd0);
        checkOutput("reset.lkp_ready", 32'(lkp_ready_o),   32'd0);
        checkOutput("reset.fill_rdy",  32'(fill_ready_o),  32'd0);
        checkOutput("reset.busy",      32'(busy_o),        32'd1);
        checkOutput("reset.hit_cnt",   hit_cnt_o,          32'd0);
        checkOutput("reset.miss_cnt",  miss_cnt_o,         32'd0);
        reset = 1'b0;
        countWhileBusy(n);
        checkOutput("init.busy_cycles", 32'(n), 32'd4);
        checkOutput("init.lkp_ready",   32'(lkp_ready_o),  32'd1);
        checkOutput("init.fill_ready",  32'(fill_ready_o), 32'd1);

        lookup("cold_miss", 2'd1, 20'h123, 1'b0, 2'd0, 32'd0);

        fill(2'd2, 20'hA, 32'd1);
        checkOutput("rsp_pulse_end", 32'(rsp_valid_o), 32'd0);
        fill(2'd2, 20'hB, 32'd2);
        fill(2'd2, 20'hC, 32'd3);
        fill(2'd2, 20'hD, 32'd4);
        lookup("hit_c", 2'd2, 20'hC, 1'b1, 2'd2, 32'd3);

        // Touch w0..w3 then w0: tree points at way 2 as victim.
        lookup("touch_a", 2'd2, 20'hA, 1'b1, 2'd0, 32'd1);
        lookup("touch_b", 2'd2, 20'hB, 1'b1, 2'd1, 32'd2);
        lookup("touch_c", 2'd2, 20'hC, 1'b1, 2'd2, 32'd3);
        lookup("touch_d", 2'd2, 20'hD, 1'b1, 2'd3, 32'd4);
        lookup("touch_a2", 2'd2, 20'hA, 1'b1, 2'd0, 32'd1);
        fill(2'd2, 20'hE, 32'd5);
        lookup("evicted_c", 2'd2, 20'hC, 1'b0, 2'd0, 32'd0);
        lookup("kept_a",    2'd2, 20'hA, 1'b1, 2'd0, 32'd1);

        // Victim is now way 3, so an in-place overwrite is distinguishable.
        fill(2'd2, 20'hB, 32'h99);
        lookup("inplace_b", 2'd2, 20'hB, 1'b1, 2'd1, 32'h99);
        lookup("kept_d",    2'd2, 20'hD, 1'b1, 2'd3, 32'd4);
        lookup("kept_e",    2'd2, 20'hE, 1'b1, 2'd2, 32'd5);

        applyStimulus(1'b1, 2'd3, 20'h5, 1'b1, 2'd3, 20'h5, 32'h55, 1'b0);
        checkResponse("rbw_miss", 1'b0, 2'd0, 32'd0);
        lookup("rbw_hit", 2'd3, 20'h5, 1'b1, 2'd0, 32'h55);

        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("stats.hits",   hit_cnt_o,  EXP_HITS);
        checkOutput("stats.misses", miss_cnt_o, EXP_MISSES);

        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
        n = 0;
        while (!lkp_ready_o && n < 20) begin
            n++;
            tick();
        end
        checkOutput("flush.cycles",     32'(n), 32'd4);
        checkOutput("flush.hit_cnt",    hit_cnt_o,  32'd0);
        checkOutput("flush.miss_cnt",   miss_cnt_o, 32'd0);
        lookup("flushed_a", 2'd2, 20'hA, 1'b0, 2'd0, 32'd0);
        lookup("flushed_d", 2'd2, 20'hD, 1'b0, 2'd0, 32'd0);
        lookup("flushed_5", 2'd3, 20'h5, 1'b0, 2'd0, 32'd0);

        // Reset in the same cycle as an accepted lookup drops its response.
        fill(2'd0, 20'h77, 32'h7);
        lkp_valid_i = 1'b1;
        lkp_idx_i   = 2'd0;
        lkp_tag_i   = 20'h77;
        reset       = 1'b1;
        tick();
        lkp_valid_i = 1'b0;
        checkOutput("drop.rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("drop.busy",      32'(busy_o),      32'd1);
        reset = 1'b0;
        countWhileBusy(n);
        checkOutput("drop.busy_cycles", 32'(n), 32'd4);
        lookup("after_reset_77", 2'd0, 20'h77, 1'b0, 2'd0, 32'd0);

        // Reset in the middle of a flush sweep restarts a full init.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
        checkOutput("midflush.busy", 32'(busy_o), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midflush.hit_cnt",  hit_cnt_o,  32'd0);
        checkOutput("midflush.miss_cnt", miss_cnt_o, 32'd0);
        countWhileBusy(n);
        checkOutput("midflush.busy_cycles", 32'(n), 32'd4);
        checkOutput("midflush.ready", 32'(lkp_ready_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
